// File: rtl/axi4_lite_register_pkg.sv
// Shared types for the AXI4-lite register controller: FSM state encoding,
// read/write grant type, response codes and the controller status struct.
package axi4_lite_register_pkg;

   // Transaction sequencer states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WRITE   = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_READ    = 3'd3,
      ST_RD_RESP = 3'd4
   } state_e;

   // Which transaction type won the most recent contested arbitration
   typedef enum logic {
      GNT_READ  = 1'b0,
      GNT_WRITE = 1'b1
   } grant_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Control state of the sequencer; kept in one struct so the whole FSM
   // context (state, holding flags, arbitration pointer) is visible at once.
   typedef struct packed {
      state_e state;
      logic   aw_held;
      logic   w_held;
      logic   ar_held;
      grant_e last_grant;
   } ctrl_t;

   localparam ctrl_t CTRL_RESET = '{
      state:      ST_IDLE,
      aw_held:    1'b0,
      w_held:     1'b0,
      ar_held:    1'b0,
      last_grant: GNT_READ
   };

endpackage

// File: rtl/axi4_lite_register_decode.sv
// Address decoder: register select field, one-hot select and out-of-range flag.
// The range flag is only produced when AXI4_LITE_REGISTER_CTRL_DECERR_EN is
// defined; otherwise upper address bits alias onto the register file.
module axi4_lite_register_decode
   import axi4_lite_register_pkg::*;
#(
   parameter int N  = 4,
   parameter int MW = 3,
   parameter int MI = 2**MW,
   parameter int A  = 32
) (
   input  logic [A-1:0]  addr,
   output logic [MW-1:0] sel,
   output logic [MI-1:0] onehot,
   output logic          range_err
);

   localparam int LB = $clog2(N);
   localparam int HI = LB + MW;

   // Byte-lane bits below the select field carry no meaning for word registers
   logic unused_low_bits;
   assign unused_low_bits = ^addr[LB-1:0];

   assign sel = addr[HI-1:LB];

   // One-hot select; select codes at or beyond MI decode to no register
   always_comb begin
      onehot = '0;
      for (int i = 0; i < MI; i++) begin
         onehot[i] = (sel == MW'(i));
      end
   end

   generate
      if (A > HI) begin : g_upper
         logic upper_nz;
         assign upper_nz = |addr[A-1:HI];
`ifdef AXI4_LITE_REGISTER_CTRL_DECERR_EN
         assign range_err = upper_nz;
`else
         logic unused_upper;
         assign unused_upper = upper_nz;
         assign range_err    = 1'b0;
`endif
      end else begin : g_no_upper
         assign range_err = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/axi4_lite_register_ctrl.sv
// AXI4-lite slave front end for a flat register file.
// AW, W and AR are each captured in a single-entry holding register; a small
// sequencer serialises writes and reads onto one-cycle register-side enable
// pulses and then presents the B or R response.
// Handshake rule on every channel: a transfer happens on the rising clock
// edge where valid and ready are both high; valid, once raised, is held with
// stable payload until that edge, and responses stay stable while pending.
// Optional feature: define AXI4_LITE_REGISTER_CTRL_DECERR_EN to answer
// addresses with nonzero bits above the select field with DECERR instead of
// aliasing them onto the register file.
module axi4_lite_register_ctrl
   import axi4_lite_register_pkg::*;
#(
   parameter int N  = 4,
   parameter int MW = 3,
   parameter int MI = 2**MW,
   parameter int A  = 32
) (
   input  logic              aclk,
   input  logic              aresetn,
   // write address
   input  logic [A-1:0]      awaddr,
   input  logic              awvalid,
   output logic              awready,
   // write data
   input  logic [8*N-1:0]    wdata,
   input  logic [N-1:0]      wstrb,
   input  logic              wvalid,
   output logic              wready,
   // write response
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready,
   // read address
   input  logic [A-1:0]      araddr,
   input  logic              arvalid,
   output logic              arready,
   // read data
   output logic [8*N-1:0]    rdata,
   output logic [1:0]        rresp,
   output logic              rvalid,
   input  logic              rready,
   // register side
   input  logic [8*N-1:0]    reg_in [MI],
   output logic [8*N-1:0]    reg_wdata,
   output logic [MI-1:0]     reg_wr_en,
   output logic [MI-1:0]     reg_rd_en
);

   localparam int DW = 8 * N;

   // Reject unsupported bus widths and address widths too narrow for the map
   generate
      if (N != 4 && N != 8) begin : g_bad_n
         $fatal(1, "axi4_lite_register_ctrl: N must be 4 or 8");
      end
      if (A < MW + $clog2(N)) begin : g_bad_a
         $fatal(1, "axi4_lite_register_ctrl: A too small for MW and N");
      end
   endgenerate

   ctrl_t            ctrl_q, ctrl_d;
   logic             rdy_q, rdy_d;
   logic [A-1:0]     awaddr_q, awaddr_d;
   logic [A-1:0]     araddr_q, araddr_d;
   logic [DW-1:0]    wdata_q, wdata_d;
   logic [N-1:0]     wstrb_q, wstrb_d;
   logic [DW-1:0]    rdata_q, rdata_d;
   logic [1:0]       bresp_q, bresp_d;
   logic [1:0]       rresp_q, rresp_d;

   logic [MW-1:0]    aw_sel, ar_sel;
   logic [MI-1:0]    aw_onehot, ar_onehot;
   logic             aw_err, ar_err;
   logic [DW-1:0]    wr_cur, rd_word;
   logic             aw_fire, w_fire, ar_fire;
   logic             wr_ok, rd_ok;

   // One decoder per address channel, fed from the held address
   axi4_lite_register_decode #(
      .N (N), .MW(MW), .MI(MI), .A(A)
   ) u_aw_dec (
      .addr     (awaddr_q),
      .sel      (aw_sel),
      .onehot   (aw_onehot),
      .range_err(aw_err)
   );

   axi4_lite_register_decode #(
      .N (N), .MW(MW), .MI(MI), .A(A)
   ) u_ar_dec (
      .addr     (araddr_q),
      .sel      (ar_sel),
      .onehot   (ar_onehot),
      .range_err(ar_err)
   );

   // Readies stay low through reset and open one clock after release
   assign awready = rdy_q & ~ctrl_q.aw_held;
   assign wready  = rdy_q & ~ctrl_q.w_held;
   assign arready = rdy_q & ~ctrl_q.ar_held;

   assign aw_fire = awvalid & awready;
   assign w_fire  = wvalid  & wready;
   assign ar_fire = arvalid & arready;

   assign wr_ok = ctrl_q.aw_held & ctrl_q.w_held;
   assign rd_ok = ctrl_q.ar_held;

   // Current contents of the addressed registers (zero for unmapped selects)
   always_comb begin
      wr_cur  = '0;
      rd_word = '0;
      if (int'(aw_sel) < MI) wr_cur  = reg_in[aw_sel];
      if (int'(ar_sel) < MI) rd_word = reg_in[ar_sel];
   end

   // Next-state logic: arbitration, holding registers and response capture
   always_comb begin
      ctrl_d   = ctrl_q;
      rdy_d    = 1'b1;
      awaddr_d = awaddr_q;
      araddr_d = araddr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      rdata_d  = rdata_q;
      bresp_d  = bresp_q;
      rresp_d  = rresp_q;

      case (ctrl_q.state)
         ST_IDLE: begin
            // The priority pointer only moves when both types compete, so an
            // uncontested grant does not cost the other type its turn.
            if (wr_ok && rd_ok) begin
               if (ctrl_q.last_grant == GNT_READ) begin
                  ctrl_d.state      = ST_WRITE;
                  ctrl_d.last_grant = GNT_WRITE;
               end else begin
                  ctrl_d.state      = ST_READ;
                  ctrl_d.last_grant = GNT_READ;
               end
            end else if (wr_ok) begin
               ctrl_d.state = ST_WRITE;
            end else if (rd_ok) begin
               ctrl_d.state = ST_READ;
            end
         end
         ST_WRITE: begin
            ctrl_d.aw_held = 1'b0;
            ctrl_d.w_held  = 1'b0;
            bresp_d        = aw_err ? RESP_DECERR : RESP_OKAY;
            ctrl_d.state   = ST_WR_RESP;
         end
         ST_WR_RESP: begin
            if (bready) ctrl_d.state = ST_IDLE;
         end
         ST_READ: begin
            ctrl_d.ar_held = 1'b0;
            rdata_d        = ar_err ? '0 : rd_word;
            rresp_d        = ar_err ? RESP_DECERR : RESP_OKAY;
            ctrl_d.state   = ST_RD_RESP;
         end
         ST_RD_RESP: begin
            if (rready) ctrl_d.state = ST_IDLE;
         end
         default: begin
            ctrl_d.state = ST_IDLE;
         end
      endcase

      // A channel can only fire while its holder is empty, so these never
      // collide with the clears above.
      if (aw_fire) begin
         ctrl_d.aw_held = 1'b1;
         awaddr_d       = awaddr;
      end
      if (w_fire) begin
         ctrl_d.w_held = 1'b1;
         wdata_d       = wdata;
         wstrb_d       = wstrb;
      end
      if (ar_fire) begin
         ctrl_d.ar_held = 1'b1;
         araddr_d       = araddr;
      end
   end

   // Byte-merged write data, driven only during the WRITE cycle
   always_comb begin
      reg_wdata = '0;
      if (ctrl_q.state == ST_WRITE) begin
         for (int b = 0; b < N; b++) begin
            reg_wdata[8*b +: 8] = wstrb_q[b] ? wdata_q[8*b +: 8] : wr_cur[8*b +: 8];
         end
      end
   end

   // Register-side enables: one-hot, only in WRITE/READ, suppressed on DECERR
   always_comb begin
      reg_wr_en = '0;
      reg_rd_en = '0;
      if (ctrl_q.state == ST_WRITE && !aw_err) reg_wr_en = aw_onehot;
      if (ctrl_q.state == ST_READ  && !ar_err) reg_rd_en = ar_onehot;
   end

   assign bvalid = (ctrl_q.state == ST_WR_RESP);
   assign rvalid = (ctrl_q.state == ST_RD_RESP);
   assign bresp  = bresp_q;
   assign rresp  = rresp_q;
   assign rdata  = rdata_q;

   // State and datapath registers; reset drops any transaction in flight
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ctrl_q   <= CTRL_RESET;
         rdy_q    <= 1'b0;
         awaddr_q <= '0;
         araddr_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         rdata_q  <= '0;
         bresp_q  <= RESP_OKAY;
         rresp_q  <= RESP_OKAY;
      end else begin
         ctrl_q   <= ctrl_d;
         rdy_q    <= rdy_d;
         awaddr_q <= awaddr_d;
         araddr_q <= araddr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         rdata_q  <= rdata_d;
         bresp_q  <= bresp_d;
         rresp_q  <= rresp_d;
      end
   end

endmodule

// File: tb/tb_axi4_lite_register_ctrl.sv
// Directed bench for axi4_lite_register_ctrl (N=4, MW=3, A=8).
// Expected register-side events and responses are queued as stimulus is
// issued and matched in order by a negedge monitor.
module tb_axi4_lite_register_ctrl;

   localparam int N  = 4;
   localparam int MW = 3;
   localparam int MI = 8;
   localparam int A  = 8;
   localparam int DW = 32;
   localparam int W  = 37;

   localparam logic [1:0] K_WR = 2'd0;
   localparam logic [1:0] K_RD = 2'd1;
   localparam logic [1:0] K_B  = 2'd2;
   localparam logic [1:0] K_R  = 2'd3;
   localparam logic [W-1:0] SENTINEL = {2'b11, 3'b111, 32'hFFFF_FFFF};

   logic            aclk = 1'b0;
   logic            aresetn = 1'b0;
   logic [A-1:0]    awaddr, araddr;
   logic            awvalid, awready, wvalid, wready, arvalid, arready;
   logic [DW-1:0]   wdata, rdata, reg_wdata;
   logic [N-1:0]    wstrb;
   logic [1:0]      bresp, rresp;
   logic            bvalid, bready, rvalid, rready;
   logic [MI-1:0]   reg_wr_en, reg_rd_en;
   logic [DW-1:0]   reg_mem [MI] = '{0: 32'h0BAD_0000, 1: 32'h1122_3344,
                                     2: 32'h0102_0304, 3: 32'h0303_0303,
                                     4: 32'hC0DE_0004, 5: 32'hC0DE_0005,
                                     6: 32'h0606_0606, 7: 32'h5A5A_0001};

   logic [W-1:0]    exp_q[$];
   int              n_checks = 0;
   int              n_fail   = 0;
   int              wr_pulses = 0, rd_pulses = 0, exp_wr = 0, exp_rd = 0;
   int              rd_before;
   logic [DW-1:0]   rnd;

   axi4_lite_register_ctrl #(.N(N), .MW(MW), .MI(MI), .A(A)) dut (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .awaddr   (awaddr),
      .awvalid  (awvalid),
      .awready  (awready),
      .wdata    (wdata),
      .wstrb    (wstrb),
      .wvalid   (wvalid),
      .wready   (wready),
      .bresp    (bresp),
      .bvalid   (bvalid),
      .bready   (bready),
      .araddr   (araddr),
      .arvalid  (arvalid),
      .arready  (arready),
      .rdata    (rdata),
      .rresp    (rresp),
      .rvalid   (rvalid),
      .rready   (rready),
      .reg_in   (reg_mem),
      .reg_wdata(reg_wdata),
      .reg_wr_en(reg_wr_en),
      .reg_rd_en(reg_rd_en)
   );

   // ---------------- clock / reset ----------------
   always #5 aclk = ~aclk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // Register file behind the controller
   always @(posedge aclk) begin
      for (int i = 0; i < MI; i++) begin
         if (reg_wr_en[i]) reg_mem[i] <= reg_wdata;
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] ev(input logic [1:0] kind, input logic [2:0] f,
                                       input logic [31:0] d);
      return {kind, f, d};
   endfunction

   function automatic logic [2:0] enc(input logic [MI-1:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < MI; i++) if (v[i]) r = 3'(i);
      return r;
   endfunction

   task automatic push_wr(input logic [2:0] idx, input logic [31:0] d);
      exp_q.push_back(ev(K_WR, idx, d));
      exp_wr++;
   endtask

   task automatic push_rd(input logic [2:0] idx);
      exp_q.push_back(ev(K_RD, idx, 32'h0));
      exp_rd++;
   endtask

   task automatic push_b(input logic [1:0] resp);
      exp_q.push_back(ev(K_B, {1'b0, resp}, 32'h0));
   endtask

   task automatic push_r(input logic [1:0] resp, input logic [31:0] d);
      exp_q.push_back(ev(K_R, {1'b0, resp}, d));
   endtask

   task automatic sb_pop(input string tag, input logic [W-1:0] obs);
      logic [W-1:0] e;
      e = SENTINEL;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check(tag, 64'(obs), 64'(e));
   endtask

   // Monitor: sample away from the active edge and match events in order
   always @(negedge aclk) begin
      if (aresetn) begin
         if (|{reg_wr_en, reg_rd_en})
            check("one_enable", 64'($countones({reg_wr_en, reg_rd_en})), 64'd1);
         if (|reg_wr_en) begin
            wr_pulses++;
            sb_pop("sb_wr", ev(K_WR, enc(reg_wr_en), reg_wdata));
         end
         if (|reg_rd_en) begin
            rd_pulses++;
            sb_pop("sb_rd", ev(K_RD, enc(reg_rd_en), 32'h0));
         end
         if (bvalid && bready) sb_pop("sb_b", ev(K_B, {1'b0, bresp}, 32'h0));
         if (rvalid && rready) sb_pop("sb_r", ev(K_R, {1'b0, rresp}, rdata));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycles(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   // Raise the selected valids and drop each one after its handshake edge
   task automatic issue(input bit do_aw, input bit do_w, input bit do_ar);
      bit a, w, r;
      awvalid = do_aw;
      wvalid  = do_w;
      arvalid = do_ar;
      for (int c = 0; c < 50 && (awvalid || wvalid || arvalid); c++) begin
         @(negedge aclk);
         a = awvalid && awready;
         w = wvalid && wready;
         r = arvalid && arready;
         @(posedge aclk);
         #1;
         if (a) awvalid = 1'b0;
         if (w) wvalid  = 1'b0;
         if (r) arvalid = 1'b0;
      end
      check("issue_accepted", {61'd0, awvalid, wvalid, arvalid}, 64'd0);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      arvalid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
         @(posedge aclk);
         #1;
      end
      check(tag, 64'(exp_q.size()), 64'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      bready = 1'b1; rready = 1'b1;

      // Reset values
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("rst_ready",  {61'd0, awready, wready, arready}, 64'd0);
      check("rst_valid",  {62'd0, bvalid, rvalid}, 64'd0);
      check("rst_enable", {48'd0, reg_wr_en, reg_rd_en}, 64'd0);
      check("rst_data",   {reg_wdata, rdata}, 64'd0);
      check("rst_resp",   {60'd0, bresp, rresp}, 64'd0);
      @(posedge aclk); #1 aresetn = 1'b1;
      @(posedge aclk); #1;
      check("ready_after_rst", {61'd0, awready, wready, arready}, 64'd7);

      // Simultaneous AW+W, full strobe, latency
      awaddr = 8'h08; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
      push_wr(3'd2, 32'hDEAD_BEEF);
      push_b(2'b00);
      issue(1, 1, 0);
      @(negedge aclk);
      check("wr_lat_c1", 64'(reg_wr_en), 64'h0);
      @(negedge aclk);
      check("wr_lat_c2", 64'(reg_wr_en), 64'h04);
      check("wr_lat_wdata", 64'(reg_wdata), 64'hDEAD_BEEF);
      @(negedge aclk);
      check("b_lat_c3", 64'(bvalid), 64'd1);
      check("wr_en_c3", 64'(reg_wr_en), 64'h0);
      check("bresp_okay", 64'(bresp), 64'd0);
      wait_drain("drain_full_write");

      // W leads AW by three cycles, partial strobe merges with reg_in
      wdata = 32'hAABB_CCDD; wstrb = 4'h3;
      push_wr(3'd1, 32'h1122_CCDD);
      push_b(2'b00);
      issue(0, 1, 0);
      cycles(2);
      awaddr = 8'h04;
      issue(1, 0, 0);
      wait_drain("drain_partial_write");

      // Read with rready held low; response must stay stable
      rready = 1'b0; araddr = 8'h1C;
      rd_before = rd_pulses;
      push_rd(3'd7);
      push_r(2'b00, 32'h5A5A_0001);
      issue(0, 0, 1);
      for (int c = 0; c < 10 && !rvalid; c++) @(negedge aclk);
      check("r_valid_seen", 64'(rvalid), 64'd1);
      for (int c = 0; c < 4; c++) begin
         check("r_hold_valid", 64'(rvalid), 64'd1);
         check("r_hold_data", 64'(rdata), 64'h5A5A_0001);
         @(negedge aclk);
      end
      @(posedge aclk); #1 rready = 1'b1;
      wait_drain("drain_stalled_read");
      check("rd_pulse_once", 64'(rd_pulses - rd_before), 64'd1);

      // Contention round 1: write wins, then read
      awaddr = 8'h10; wdata = 32'hA1A2_A3A4; wstrb = 4'hF; araddr = 8'h14;
      push_wr(3'd4, 32'hA1A2_A3A4);
      push_b(2'b00);
      push_rd(3'd5);
      push_r(2'b00, 32'hC0DE_0005);
      issue(1, 1, 1);
      wait_drain("drain_round1");

      // Contention round 2: read wins, sees round-1 data, then write
      awaddr = 8'h14; wdata = 32'hB1B2_B3B4; wstrb = 4'h5; araddr = 8'h10;
      push_rd(3'd4);
      push_r(2'b00, 32'hA1A2_A3A4);
      push_wr(3'd5, 32'hC0B2_00B4);
      push_b(2'b00);
      issue(1, 1, 1);
      wait_drain("drain_round2");

      // Addresses above the select field
      awaddr = 8'h40; wdata = 32'h1234_5678; wstrb = 4'hF;
`ifdef AXI4_LITE_REGISTER_CTRL_DECERR_EN
      push_b(2'b11);
`else
      push_wr(3'd0, 32'h1234_5678);
      push_b(2'b00);
`endif
      issue(1, 1, 0);
      wait_drain("drain_high_write");
      araddr = 8'h9C;
`ifdef AXI4_LITE_REGISTER_CTRL_DECERR_EN
      push_r(2'b11, 32'h0);
`else
      push_rd(3'd7);
      push_r(2'b00, 32'h5A5A_0001);
`endif
      issue(0, 0, 1);
      wait_drain("drain_high_read");

      // Reset while a write response is pending
      bready = 1'b0;
      awaddr = 8'h0C; wdata = 32'h3333_3333; wstrb = 4'hF;
      push_wr(3'd3, 32'h3333_3333);
      issue(1, 1, 0);
      for (int c = 0; c < 10 && !bvalid; c++) @(negedge aclk);
      check("b_pending", 64'(bvalid), 64'd1);
      @(posedge aclk); #1 aresetn = 1'b0;
      #1;
      check("rst_drops_b", 64'(bvalid), 64'd0);
      check("rst_mid_ready", {61'd0, awready, wready, arready}, 64'd0);
      @(negedge aclk);
      check("rst_mid_enable", {48'd0, reg_wr_en, reg_rd_en}, 64'd0);
      @(posedge aclk); #1 aresetn = 1'b1; bready = 1'b1;
      @(posedge aclk); #1;
      check("ready_after_rst2", {61'd0, awready, wready, arready}, 64'd7);
      cycles(4);
      @(negedge aclk);
      check("no_stale_b", 64'(bvalid), 64'd0);
      @(posedge aclk); #1;

      // Fresh write after reset, then read it back
      rnd = $urandom();
      awaddr = 8'h18; wdata = rnd; wstrb = 4'hF;
      push_wr(3'd6, rnd);
      push_b(2'b00);
      issue(1, 1, 0);
      wait_drain("drain_post_rst_write");
      araddr = 8'h18;
      push_rd(3'd6);
      push_r(2'b00, rnd);
      issue(0, 0, 1);
      wait_drain("drain_post_rst_read");

      // ---------------- report ----------------
      check("wr_pulse_total", 64'(wr_pulses), 64'(exp_wr));
      check("rd_pulse_total", 64'(rd_pulses), 64'(exp_rd));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
